pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 28 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 139 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and elaboration helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor sequencing states.
    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABILIZE  = 3'd2,
        READY      = 3'd3,
        FAULT      = 3'd4
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n-1, never less than one so that
    // degenerate parameter choices still give a legal vector.
    function automatic int width_for(input int n);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous status bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the core PLL reset, qualifies its lock with timeout and bounded
// retries, and reports a clean ready flag plus a lock-loss counter.
// The state port is a debug view of the sequencer.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 8
) (
    input  logic                                 refclk,
    input  logic                                 rst_n,
    input  logic                                 soft_reset,
    input  logic                                 pll_locked,
    output logic                                 pll_rst,
    output logic                                 pll_ready,
    output logic                                 fault,
    output logic [width_for(MAX_RETRIES+1)-1:0]  retry_cnt,
    output logic [CNT_W-1:0]                     lock_loss_cnt,
    output state_t                               state
);

    // One counter is shared by every timed state, so it is sized for the
    // longest interval; terminal values are compared exactly and never wrap.
    localparam int CW = width_for(max_of(max_of(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                         LOCK_TIMEOUT));
    localparam int RW = width_for(MAX_RETRIES + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    logic          locked_s;
    logic [CW-1:0] cnt;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Lock-qualification sequencer; all outputs are registered here.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_HOLD;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            pll_ready     <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else if (soft_reset) begin
            // Full re-lock from any state; the loss history is status, kept.
            state     <= RESET_HOLD;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins.
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state     <= RESET_HOLD;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABILIZE: begin
                    // A glitch restarts the wait window without burning a retry.
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= READY;
                        cnt       <= '0;
                        pll_ready <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (!locked_s) begin
                        state     <= RESET_HOLD;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        pll_ready <= 1'b0;
                        if (lock_loss_cnt != {CNT_W{1'b1}}) begin
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    pll_rst   <= 1'b1;
                    pll_ready <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state     <= RESET_HOLD;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    pll_ready <= 1'b0;
                    fault     <= 1'b0;
                    retry_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised bench for pll_lock_supervisor. A reference model steps once per
// refclk edge from the observed inputs and queues the expected outputs; a
// monitor on the falling edge pops and compares.
// Handshake: the model pushes exactly one expected word per rising edge while
// rst_n is high; the monitor pops one word per falling edge when one is queued.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int SYNC   = 2;
    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int TMO    = 32;
    localparam int MAXR   = 2;
    localparam int LW     = 2;
    localparam int EW     = 3 + 2 + LW;

    // ---------------- clock / reset ----------------
    logic refclk = 1'b0;
    logic rst_n;
    logic soft_reset;
    logic pll_locked;

    always #5 refclk = ~refclk;

    logic          pll_rst, pll_ready, fault;
    logic [1:0]    retry_cnt;
    logic [LW-1:0] lock_loss_cnt;
    state_t        state;

    pll_lock_supervisor #(
        .SYNC_STAGES        (SYNC),
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT       (TMO),
        .MAX_RETRIES        (MAXR),
        .CNT_W              (LW)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .soft_reset    (soft_reset),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .pll_ready     (pll_ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Phases are tracked with "edges remaining" countdowns; the synchroniser
    // is modelled as the input value seen SYNC edges earlier.
    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STAB = 2, PH_READY = 3, PH_FAULT = 4;
    int m_phase   = PH_HOLD;
    int m_left    = HOLD;
    int m_retries = 0;
    int m_losses  = 0;
    int lk_hist[$] = '{0, 0};

    function automatic logic [EW-1:0] model_out();
        logic r, d, f;
        r = (m_phase == PH_HOLD) || (m_phase == PH_FAULT);
        d = (m_phase == PH_READY);
        f = (m_phase == PH_FAULT);
        return {r, d, f, 2'(m_retries), LW'(m_losses)};
    endfunction

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   = PH_HOLD;
            m_left    = HOLD;
            m_retries = 0;
            m_losses  = 0;
            lk_hist   = '{0, 0};
            exp_q.delete();
        end else begin
            int ls;
            ls = lk_hist[$];
            lk_hist.pop_back();
            lk_hist.push_front(int'(pll_locked));
            if (soft_reset) begin
                m_phase   = PH_HOLD;
                m_left    = HOLD;
                m_retries = 0;
            end else begin
                case (m_phase)
                    PH_HOLD: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_WAIT;
                            m_left  = TMO;
                        end
                    end
                    PH_WAIT: begin
                        if (ls != 0) begin
                            m_phase = PH_STAB;
                            m_left  = STABLE;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                if (m_retries == MAXR) begin
                                    m_phase = PH_FAULT;
                                end else begin
                                    m_retries++;
                                    m_phase = PH_HOLD;
                                    m_left  = HOLD;
                                end
                            end
                        end
                    end
                    PH_STAB: begin
                        if (ls == 0) begin
                            m_phase = PH_WAIT;
                            m_left  = TMO;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                m_phase   = PH_READY;
                                m_retries = 0;
                            end
                        end
                    end
                    PH_READY: begin
                        if (ls == 0) begin
                            m_phase = PH_HOLD;
                            m_left  = HOLD;
                            if (m_losses < (1 << LW) - 1) m_losses++;
                        end
                    end
                    default: ;
                endcase
            end
            exp_q.push_back(model_out());
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] reset_word;
    assign reset_word = {1'b1, 1'b0, 1'b0, 2'd0, {LW{1'b0}}};

    always @(negedge refclk) begin
        logic [EW-1:0] got, exp;
        got = {pll_rst, pll_ready, fault, retry_cnt, lock_loss_cnt};
        if (!rst_n) begin
            checks++;
            if (got !== reset_word) begin
                errors++;
                $display("FAIL reset_values: got %b required %b at %0t", got, reset_word, $time);
            end
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL outputs {rst,rdy,flt,retry,loss}: got %b required %b at %0t",
                         got, exp, $time);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic pulse_soft();
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
    endtask

    task automatic pulse_rst(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        soft_reset = 1'b0;
        pll_locked = 1'b1;
        tick(3);

        // Clean first lock with the PLL already locked.
        rst_n = 1'b1;
        tick(30);

        // Five losses from READY: counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            tick($urandom_range(1, 6));
            pll_locked = 1'b1;
            tick(30);
        end

        // One-cycle glitch while stabilising.
        pll_locked = 1'b0;
        tick(10);
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(30);

        // Never locks: retries exhausted, FAULT, then soft reset recovers.
        pll_locked = 1'b0;
        tick(130);
        pulse_soft();
        pll_locked = 1'b1;
        tick(30);

        // Async reset mid-stabilise.
        pll_locked = 1'b0;
        tick(8);
        pll_locked = 1'b1;
        tick(6);
        pulse_rst(3);
        tick(30);

        // Soft reset swept across the first WAIT_LOCK timeout edge.
        for (int k = 30; k <= 40; k++) begin
            pll_locked = 1'b0;
            pulse_rst(2);
            tick(k);
            pulse_soft();
            tick(3);
        end

        // Random lock activity with occasional soft and hard resets.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                pulse_soft();
            end else if (r < 5) begin
                pulse_rst($urandom_range(1, 3));
            end
            pll_locked = ($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 40));
        end

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
